ddr_tx: RTL

HDR-DDR transmit serializer for the I3C controller. It sits directly downstream of the DDR-mode engine FSM: it consumes the engine's `o_tx_en`/`o_tx_mode` and the register-file read byte, and drives the serial SDA value. It generates preambles, data bits, parity, the CRC token and the CRC5 checksum, and returns a one-cycle `o_tx_mode_done` per completed mode.

---
 rtl/ddr_pkg.sv | 44 ++++
 rtl/crc5_ddr.sv | 26 ++
 rtl/ddr_tx.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ddr_pkg.sv
// Shared HDR-DDR definitions: tx mode codes, token and CRC5 constants.
package ddr_pkg;

   typedef enum logic [3:0] {
      TX_IDLE        = 4'd0,
      TX_SPECIAL_PRE = 4'd1,
      TX_ONE_PRE     = 4'd2,
      TX_ZERO_PRE    = 4'd3,
      TX_SERIAL_BYTE = 4'd4,
      TX_PARITY      = 4'd5,
      TX_TOKEN_CRC   = 4'd6,
      TX_CRC_VALUE   = 4'd7
   } tx_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic [3:0] TX_TOKEN = 4'b1100;
   localparam logic [4:0] CRC_POLY = 5'b00101;
   localparam logic [4:0] CRC_INIT = 5'h1F;

   // Codes 8-15 alias to idle.
   function automatic logic mode_is_idle(input logic [3:0] m);
      return (m == TX_IDLE) || m[3];
   endfunction

   function automatic logic [3:0] mode_len(input logic [3:0] m);
      logic [3:0] n;
      unique case (m)
         TX_SPECIAL_PRE: n = 4'd2;
         TX_ONE_PRE:     n = 4'd1;
         TX_ZERO_PRE:    n = 4'd1;
         TX_SERIAL_BYTE: n = 4'd8;
         TX_PARITY:      n = 4'd2;
         TX_TOKEN_CRC:   n = 4'd4;
         TX_CRC_VALUE:   n = 4'd5;
         default:        n = 4'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/crc5_ddr.sv
// Serial MSB-first CRC5 (x^5+x^2+1); init has priority over a bit update.
module crc5_ddr
   import ddr_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init,
   input  logic       valid,
   input  logic       din,
   output logic [4:0] crc
);

   logic fb;

   assign fb = crc[4] ^ din;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         crc <= CRC_INIT;
      else if (init)
         crc <= CRC_INIT;
      else if (valid)
         crc <= {crc[3:0], 1'b0} ^ (fb ? CRC_POLY : 5'b0);
   end

endmodule

// File: rtl/ddr_tx.sv
// HDR-DDR transmit serializer: preambles, bytes, parity, CRC token and CRC5.
module ddr_tx
   import ddr_pkg::*;
#(
   parameter int TICK_MIN = 3
) (
   input  logic       i_sys_clk,
   input  logic       i_sys_rst,
   input  logic       i_tx_en,
   input  logic [3:0] i_tx_mode,
   input  logic       i_ddr_tick,
   input  logic [7:0] i_regf_data,
   output logic       o_sdaline,
   output logic       o_tx_mode_done
);

   state_e      state, state_n;
   logic [3:0]  mode_q, cur_mode;
   logic [2:0]  cnt;
   logic [7:0]  sreg, first_word;
   logic [15:0] par_word;
   logic        byte_idx, cmd_word;
   logic [4:0]  crc;
   logic        start, fire, last, tx_bit;
   logic        crc_init, crc_vld;
   logic        pa1, pa0;
   logic [3:0]  gap;

   assign pa1 = ^(par_word & 16'hAAAA);
   assign pa0 = ~^(par_word & 16'h5555);

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      fire     = 1'b0;
      cur_mode = (state == IDLE) ? i_tx_mode : mode_q;
      unique case (cur_mode)
         TX_SPECIAL_PRE: first_word = 8'b0100_0000;
         TX_ONE_PRE:     first_word = 8'h80;
         TX_ZERO_PRE:    first_word = 8'h00;
         TX_SERIAL_BYTE: first_word = i_regf_data;
         TX_PARITY:      first_word = {pa1, pa0, 6'b0};
         TX_TOKEN_CRC:   first_word = {TX_TOKEN, 4'b0};
         TX_CRC_VALUE:   first_word = {crc, 3'b0};
         default:        first_word = 8'hFF;
      endcase
      tx_bit = (state == IDLE) ? first_word[7] : sreg[7];
      if (!i_tx_en) begin
         state_n = IDLE;
      end else if (i_ddr_tick) begin
         if (state == SEND) begin
            fire = 1'b1;
         end else if (!mode_is_idle(i_tx_mode)) begin
            start = 1'b1;
            fire  = 1'b1;
         end
      end
      last = fire && ({1'b0, cnt} == mode_len(cur_mode) - 4'd1);
      if (fire)
         state_n = last ? IDLE : SEND;
      // The CRC snapshot is already in sreg when the CRC mode ends.
      crc_init = !i_tx_en
              || (state == IDLE && mode_is_idle(i_tx_mode))
              || (start && cur_mode == TX_SPECIAL_PRE)
              || (last && cur_mode == TX_CRC_VALUE);
      crc_vld = fire && cur_mode == TX_SERIAL_BYTE && !cmd_word;
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         state          <= IDLE;
         mode_q         <= TX_IDLE;
         cnt            <= '0;
         sreg           <= '0;
         par_word       <= '0;
         byte_idx       <= 1'b0;
         cmd_word       <= 1'b0;
         o_sdaline      <= 1'b1;
         o_tx_mode_done <= 1'b0;
      end else begin
         state          <= state_n;
         o_tx_mode_done <= last;
         if (!i_tx_en) begin
            o_sdaline <= 1'b1;
            cnt       <= '0;
            par_word  <= '0;
            byte_idx  <= 1'b0;
            cmd_word  <= 1'b0;
         end else if (fire) begin
            o_sdaline <= tx_bit;
            cnt       <= last ? 3'd0 : cnt + 3'd1;
            if (start) begin
               mode_q <= i_tx_mode;
               sreg   <= {first_word[6:0], 1'b0};
            end else begin
               sreg   <= {sreg[6:0], 1'b0};
            end
            if (start && cur_mode == TX_SERIAL_BYTE) begin
               if (byte_idx)
                  par_word[7:0] <= i_regf_data;
               else
                  par_word[15:8] <= i_regf_data;
               byte_idx <= ~byte_idx;
            end
            if (start && cur_mode == TX_SPECIAL_PRE)
               cmd_word <= 1'b1;
            if (last && cur_mode == TX_PARITY) begin
               par_word <= '0;
               byte_idx <= 1'b0;
               cmd_word <= 1'b0;
            end
         end else if (state == IDLE && i_ddr_tick) begin
            o_sdaline <= 1'b1;
         end
      end
   end

   crc5_ddr u_crc (
      .clk   (i_sys_clk),
      .rst_n (i_sys_rst),
      .init  (crc_init),
      .valid (crc_vld),
      .din   (tx_bit),
      .crc   (crc)
   );

   // Engine needs done plus one cycle to present the next mode.
   always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
      if (!i_sys_rst) begin
         gap <= 4'hF;
      end else if (i_ddr_tick) begin
         tick_spacing: assert (32'(gap) >= TICK_MIN - 1);
         gap <= 4'd0;
      end else if (gap != 4'hF) begin
         gap <= gap + 4'd1;
      end
   end

endmodule
